// File: rtl/s3g_pkg.sv
// Shared S3G framing constants, FSM encodings and the byte-wide CRC-8 (Maxim) step.
// The receive side imports the same package.
package s3g_pkg;

  localparam logic [7:0] S3G_START    = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;
  localparam int         S3G_MAX_LEN  = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} tx_state_t;
  typedef enum logic [1:0] {PH_START, PH_LEN, PH_PAYLOAD, PH_CRC} tx_phase_t;

  // Reflected CRC-8: fold the byte in, then shift out eight bits LSB-first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_tx_if.sv
// Byte handshake between the S3G transmitter and uart_transceiver.
interface s3g_tx_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  modport master (output tx_data, output tx_wr, input tx_done);
  modport slave  (input tx_data, input tx_wr, output tx_done);
endinterface

// File: rtl/s3g_crc8.sv
// CRC-8 (Maxim) accumulator, one byte per enabled cycle; clr wins over en.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= crc8_update(crc, d);
    end
  end

endmodule

// File: rtl/s3g_tx.sv
// S3G packet transmitter: frames the payload buffer as D5, LEN, PAYLOAD, CRC8 towards the UART.
//   state    | meaning
//   ST_IDLE  | waiting for start; payload buffer writable
//   ST_ISSUE | tx_wr high for one cycle with the byte of the current phase
//   ST_WAIT  | byte held on tx_data until tx_done, then next phase or back to idle
module s3g_tx
  import s3g_pkg::*;
#(
  parameter int MAX_LEN = S3G_MAX_LEN,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buf_wr,
  input  logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_data,
  input  logic          start,
  input  logic [7:0]    payload_len,
  s3g_tx_if.master      uart,
  output logic          busy,
  output logic          pkt_done,
  output logic          len_err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  tx_state_t  state_q, state_d;
  tx_phase_t  phase_q, phase_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] len_q;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] crc;
  logic       crc_clr, crc_en;
  logic       is_idle, accept, reject, last_byte;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_byte;
  logic [7:0] mem [MAX_LEN];

  assign is_idle   = (state_q == ST_IDLE);
  assign accept    = is_idle && start && (payload_len <= MAX_LEN_B);
  assign reject    = is_idle && start && (payload_len >  MAX_LEN_B);
  assign last_byte = (idx_q == len_q - 8'd1);

  // Buffer is frozen outside IDLE; the read looks one byte ahead for the next ISSUE.
  always_ff @(posedge clk) begin
    if (buf_wr && is_idle) begin
      mem[buf_addr] <= buf_data;
    end
  end

  assign rd_addr = (phase_q == PH_LEN) ? '0 : AW'(idx_q + 8'd1);
  assign rd_byte = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_START;
      idx_q     <= 8'd0;
      len_q     <= 8'd0;
      tx_data_q <= 8'h00;
      pkt_done  <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      if (accept) begin
        len_q <= payload_len;
      end
      pkt_done  <= (state_q == ST_WAIT) && (phase_q == PH_CRC) && uart.tx_done;
      len_err   <= reject;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ISSUE;
          phase_d   = PH_START;
          idx_d     = 8'd0;
          tx_data_d = S3G_START;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (uart.tx_done) begin
          state_d = ST_ISSUE;
          case (phase_q)
            PH_START: begin
              phase_d   = PH_LEN;
              tx_data_d = len_q;
            end
            PH_LEN: begin
              if (len_q == 8'd0) begin
                phase_d   = PH_CRC;
                tx_data_d = crc;
              end else begin
                phase_d   = PH_PAYLOAD;
                idx_d     = 8'd0;
                tx_data_d = rd_byte;
              end
            end
            PH_PAYLOAD: begin
              if (last_byte) begin
                phase_d   = PH_CRC;
                tx_data_d = crc;
              end else begin
                idx_d     = idx_q + 8'd1;
                tx_data_d = rd_byte;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uart.tx_wr   = (state_q == ST_ISSUE);
    uart.tx_data = tx_data_q;
    busy         = !is_idle;
    crc_clr      = accept;
    crc_en       = (state_q == ST_ISSUE) && (phase_q == PH_PAYLOAD);
  end

  s3g_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .d     (tx_data_q),
    .crc   (crc)
  );

endmodule

// File: tb/tb_s3g_tx.sv
// Bench for s3g_tx: table vectors, hand-written corner sequences and random packets
// compared against a frame-level reference model with a simple UART pacing model.
module tb_s3g_tx;
  import s3g_pkg::*;

  localparam int MAXL = 32;
  localparam int AW   = 5;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         len;
    int         pat;
    logic [7:0] exp_crc;
    int         exp_bytes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buf_wr = 1'b0;
  logic [AW-1:0] buf_addr = '0;
  logic [7:0]    buf_data = 8'h00;
  logic          start = 1'b0;
  logic [7:0]    payload_len = 8'h00;
  logic          busy, pkt_done, len_err;

  s3g_tx_if bus ();

  s3g_tx #(.MAX_LEN(MAXL), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .buf_wr      (buf_wr),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .start       (start),
    .payload_len (payload_len),
    .uart        (bus),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  // UART model: tx_done pulses uart_n cycles after the tx_wr cycle.
  int   uart_n = 1;
  int   ucnt = 0;
  logic model_done = 1'b0;
  logic inject = 1'b0;
  assign bus.tx_done = model_done | inject;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt       <= 0;
      model_done <= 1'b0;
    end else if (bus.tx_wr) begin
      ucnt       <= uart_n - 1;
      model_done <= (uart_n == 1);
    end else if (ucnt > 0) begin
      ucnt       <= ucnt - 1;
      model_done <= (ucnt == 1);
    end else begin
      model_done <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] got[$];
  logic [7:0] shadow [MAXL];
  int n_wr = 0, n_pd = 0, n_le = 0, hold_viol = 0, pd_busy_viol = 0;
  int last_ev = 0;
  logic [7:0] last_data = 8'h00;
  int base_wr, base_pd, base_le, base_got, base_hold;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.tx_wr) begin
        got.push_back(bus.tx_data);
        n_wr++;
        last_data = bus.tx_data;
        checks++;
        if (cyc != last_ev + 1) begin
          failures++;
          $display("FAIL tx_wr_latency: tx_wr at cycle %0d, required cycle %0d", cyc, last_ev + 1);
        end
      end else if (busy && bus.tx_data != last_data) begin
        hold_viol++;
      end
      if (pkt_done) begin
        n_pd++;
        if (busy) pd_busy_viol++;
      end
      if (len_err) n_le++;
      if ((bus.tx_done && busy && !bus.tx_wr) || (start && !busy)) last_ev = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reflected LFSR over the payload bit stream, LSB of each byte first.
  function automatic logic [7:0] crc_ref(input int len);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ shadow[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    end
    return c;
  endfunction

  function automatic bq_t frame(input int len);
    bq_t q;
    if (len > MAXL) return q;
    q.push_back(8'hD5);
    q.push_back(8'(len));
    for (int i = 0; i < len; i++) q.push_back(shadow[i]);
    q.push_back(crc_ref(len));
    return q;
  endfunction

  task automatic wr_buf(input int a, input logic [7:0] d);
    buf_wr   = 1'b1;
    buf_addr = AW'(a);
    buf_data = d;
    shadow[a] = d;
    tick();
    buf_wr = 1'b0;
  endtask

  task automatic start_pkt(input int len);
    base_wr   = n_wr;
    base_pd   = n_pd;
    base_le   = n_le;
    base_got  = got.size();
    base_hold = hold_viol;
    payload_len = 8'(len);
    start = 1'b1;
    tick();
    start  = 1'b0;
    buf_wr = 1'b0;
    @(negedge clk);
    check("len_err_next_cycle", int'(len_err), int'(len > MAXL));
    check("first_tx_wr", int'(bus.tx_wr), int'(len <= MAXL));
    tick();
  endtask

  task automatic wait_pkt(input int len);
    bq_t exp;
    int budget, mism, done_ok;
    budget  = (len + 4) * (uart_n + 4) + 20;
    done_ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (n_pd > base_pd || (len > MAXL && i >= 3)) begin
        done_ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL pkt_timeout: no pkt_done within %0d cycles for len %0d", budget, len);
    end
    tick();
    tick();
    exp = frame(len);
    check("byte_count", got.size() - base_got, exp.size());
    mism = 0;
    for (int i = 0; i < exp.size() && base_got + i < got.size(); i++) begin
      if (got[base_got + i] != exp[i]) begin
        if (mism == 0)
          $display("FAIL frame_byte[%0d] len %0d: got 0x%02h, required 0x%02h",
                   i, len, got[base_got + i], exp[i]);
        mism++;
      end
    end
    check("frame_mismatches", mism, 0);
    check("tx_wr_count", n_wr - base_wr, exp.size());
    check("pkt_done_count", n_pd - base_pd, int'(len <= MAXL));
    check("len_err_count", n_le - base_le, int'(len > MAXL));
    check("busy_after", int'(busy), 0);
    check("tx_data_hold", hold_viol - base_hold, 0);
    check("pkt_done_with_busy", pd_busy_viol, 0);
  endtask

  vec_t vt[4];
  int   nsweep[2];

  initial begin
    vt[0] = '{len: 1,  pat: 0, exp_crc: 8'h5E, exp_bytes: 4};
    vt[1] = '{len: 9,  pat: 1, exp_crc: 8'hA1, exp_bytes: 12};
    vt[2] = '{len: 0,  pat: 2, exp_crc: 8'h00, exp_bytes: 3};
    vt[3] = '{len: 33, pat: 2, exp_crc: 8'h00, exp_bytes: 0};
    nsweep[0] = 1;
    nsweep[1] = 160;
    for (int i = 0; i < MAXL; i++) shadow[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_data", int'(bus.tx_data), 0);
    check("reset_tx_wr", int'(bus.tx_wr), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pkt_done", int'(pkt_done), 0);
    check("reset_len_err", int'(len_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < MAXL; i++) wr_buf(i, 8'h00);

    foreach (nsweep[s]) begin
      uart_n = nsweep[s];
      foreach (vt[v]) begin
        if (vt[v].pat == 0) wr_buf(0, 8'h01);
        if (vt[v].pat == 1) for (int i = 0; i < 9; i++) wr_buf(i, 8'h31 + 8'(i));
        start_pkt(vt[v].len);
        wait_pkt(vt[v].len);
        check("table_bytes", got.size() - base_got, vt[v].exp_bytes);
        if (vt[v].exp_bytes > 0 && got.size() > 0)
          check("table_crc", int'(got[got.size() - 1]), int'(vt[v].exp_crc));
      end
    end

    // start and buffer write while busy are ignored
    uart_n = 3;
    for (int i = 0; i < 9; i++) wr_buf(i, 8'h31 + 8'(i));
    start_pkt(9);
    repeat (15) tick();
    check("busy_mid_packet", int'(busy), 1);
    buf_wr = 1'b1; buf_addr = '0; buf_data = 8'hFF;
    payload_len = 8'd1; start = 1'b1;
    tick();
    buf_wr = 1'b0; start = 1'b0;
    wait_pkt(9);
    start_pkt(1);
    wait_pkt(1);

    // reset during PAYLOAD aborts; next packet restarts CRC
    uart_n = 4;
    start_pkt(9);
    for (int i = 0; i < 400 && (got.size() - base_got) < 5; i++) tick();
    check("reached_payload", int'((got.size() - base_got) >= 5), 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx_wr", int'(bus.tx_wr), 0);
    check("abort_busy", int'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_no_pkt_done", n_pd - base_pd, 0);
    start_pkt(9);
    wait_pkt(9);
    check("crc_after_abort", int'(got[got.size() - 1]), 8'hA1);

    // buffer write and start in the same idle cycle
    uart_n = 2;
    buf_wr = 1'b1; buf_addr = '0; buf_data = 8'h5A; shadow[0] = 8'h5A;
    start_pkt(1);
    wait_pkt(1);

    // tx_done in idle is ignored
    base_wr = n_wr;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (4) tick();
    check("idle_tx_done_no_wr", n_wr - base_wr, 0);
    check("idle_tx_done_busy", int'(busy), 0);

    // random packets against the reference model
    for (int k = 0; k < 24; k++) begin
      int len, nw;
      uart_n = $urandom_range(1, 6);
      nw = $urandom_range(0, 8);
      for (int w = 0; w < nw; w++) wr_buf($urandom_range(0, MAXL - 1), 8'($urandom));
      if ($urandom_range(0, 7) == 0) len = $urandom_range(MAXL + 1, 255);
      else len = $urandom_range(0, MAXL);
      start_pkt(len);
      wait_pkt(len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
